runner_player: RTL and testbench

//  Consumer of the Floor/Ceiling surface streams emitted by the surface generator.

---
 rtl/runner_player_pkg.sv | 20 ++
 rtl/runner_player_btn_sync_edge.sv | 30 +++
 rtl/runner_player.sv | 146 ++++++++++++++
 tb/tb_runner_player.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/runner_player_pkg.sv
// Shared constants for the runner game: player FSM encodings and score limit.
// The display mux and game-over logic decode the same state values.
`timescale 1ns/1ps
package runner_player_pkg;

  localparam logic [2:0] ST_ON_FLOOR  = 3'd0;
  localparam logic [2:0] ST_FLIP_UP   = 3'd1;
  localparam logic [2:0] ST_ON_CEIL   = 3'd2;
  localparam logic [2:0] ST_FLIP_DOWN = 3'd3;
  localparam logic [2:0] ST_DEAD      = 3'd4;

  // Largest value a 4-digit seven-segment display can show.
  localparam int SCORE_MAX_DEF = 9999;

  // A player standing on a surface is the only one allowed to queue a flip.
  function automatic logic is_grounded(input logic [2:0] st);
    return (st == ST_ON_FLOOR) || (st == ST_ON_CEIL);
  endfunction

endpackage

// File: rtl/runner_player_btn_sync_edge.sv
// Brings the raw flip button into the Clk domain and emits a one-cycle pulse
// on each rising edge of the synchronised level.
`timescale 1ns/1ps
module btn_sync_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Two metastability flops followed by a history flop for edge detection.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= async_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise_pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/runner_player.sv
// Player logic for the runner game: samples the floor/ceiling surfaces at the
// player column on each MoveTick, runs the gravity-flip FSM, detects deaths and
// keeps a saturating score. MoveTick is a plain strobe with no back-pressure:
// every cycle it is high advances the game by one step.
`timescale 1ns/1ps
module runner_player
  import runner_player_pkg::*;
#(
  parameter int PLAYER_COL = 1,
  parameter int FLIP_TICKS = 2,
  parameter int SCORE_W    = 14,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               MoveTick,
  input  logic               FlipBtn,
  input  logic [5:0]         Floor,
  input  logic [5:0]         Ceiling,
  output logic               OnCeil,
  output logic               Airborne,
  output logic               Dead,
  output logic [SCORE_W-1:0] Score,
  output logic [2:0]         state_dbg
);

  localparam int AIR_W = $clog2(FLIP_TICKS) + 1;
  localparam logic [AIR_W-1:0]   AIR_LAST  = AIR_W'(FLIP_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [AIR_W-1:0] air_cnt;
  logic [AIR_W-1:0] air_nxt;
  logic             on_ceil_nxt;
  logic             airborne_nxt;
  logic             flip_req;
  logic             rise;
  logic             pend;
  logic             fs;
  logic             cs;
  logic             unused_cols;

  btn_sync_edge u_btn (
    .Clk        (Clk),
    .Rst        (Rst),
    .async_in   (FlipBtn),
    .rise_pulse (rise)
  );

  assign fs   = Floor[PLAYER_COL];
  assign cs   = Ceiling[PLAYER_COL];
  // An edge arriving in the MoveTick cycle itself is honoured by that tick.
  assign pend = flip_req | rise;
  // The other columns feed the display path, not the player.
  assign unused_cols = ^{Floor, Ceiling};

  assign state_dbg = state;

  // Next-state decode; a flip request wins over the gap check so a jump
  // started over a hole survives.
  always_comb begin
    state_nxt    = state;
    air_nxt      = air_cnt;
    on_ceil_nxt  = OnCeil;
    airborne_nxt = Airborne;
    case (state)
      ST_ON_FLOOR: begin
        if (pend) begin
          state_nxt    = ST_FLIP_UP;
          air_nxt      = '0;
          airborne_nxt = 1'b1;
          on_ceil_nxt  = 1'b1;
        end else if (!fs) begin
          state_nxt = ST_DEAD;
        end
      end
      ST_FLIP_UP: begin
        if (air_cnt < AIR_LAST) begin
          air_nxt = air_cnt + AIR_W'(1);
        end else if (cs) begin
          state_nxt    = ST_ON_CEIL;
          airborne_nxt = 1'b0;
        end else begin
          state_nxt = ST_DEAD;
        end
      end
      ST_ON_CEIL: begin
        if (pend) begin
          state_nxt    = ST_FLIP_DOWN;
          air_nxt      = '0;
          airborne_nxt = 1'b1;
          on_ceil_nxt  = 1'b0;
        end else if (!cs) begin
          state_nxt = ST_DEAD;
        end
      end
      ST_FLIP_DOWN: begin
        if (air_cnt < AIR_LAST) begin
          air_nxt = air_cnt + AIR_W'(1);
        end else if (fs) begin
          state_nxt    = ST_ON_FLOOR;
          airborne_nxt = 1'b0;
        end else begin
          state_nxt = ST_DEAD;
        end
      end
      ST_DEAD: begin
        state_nxt = ST_DEAD;
      end
      default: begin
        state_nxt = ST_DEAD;
      end
    endcase
    if (state_nxt == ST_DEAD) begin
      airborne_nxt = 1'b0;
    end
  end

  // Game state advances only on MoveTick; a button edge may be latched on any
  // cycle, but only while the player is standing on a surface.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= ST_ON_FLOOR;
      air_cnt  <= '0;
      OnCeil   <= 1'b0;
      Airborne <= 1'b0;
      Dead     <= 1'b0;
      Score    <= '0;
      flip_req <= 1'b0;
    end else if (MoveTick) begin
      state    <= state_nxt;
      air_cnt  <= air_nxt;
      OnCeil   <= on_ceil_nxt;
      Airborne <= airborne_nxt;
      Dead     <= (state_nxt == ST_DEAD);
      flip_req <= 1'b0;
      if ((state != ST_DEAD) && (state_nxt != ST_DEAD) && (Score != SCORE_TOP)) begin
        Score <= Score + SCORE_W'(1);
      end
    end else if (rise && is_grounded(state)) begin
      flip_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_runner_player.sv
// Directed bench for runner_player with a game-level reference model.
`timescale 1ns/1ps
module tb_runner_player;

  localparam int PLAYER_COL = 1;
  localparam int FLIP_TICKS = 2;
  localparam int SCORE_W    = 14;
  localparam int SCORE_MAX  = 9999;

  logic               Clk;
  logic               Rst;
  logic               MoveTick;
  logic               FlipBtn;
  logic [5:0]         Floor;
  logic [5:0]         Ceiling;
  logic               OnCeil;
  logic               Airborne;
  logic               Dead;
  logic [SCORE_W-1:0] Score;
  logic [2:0]         state_dbg;

  int n_chk;
  int n_pass;

  runner_player #(
    .PLAYER_COL (PLAYER_COL),
    .FLIP_TICKS (FLIP_TICKS),
    .SCORE_W    (SCORE_W),
    .SCORE_MAX  (SCORE_MAX)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .MoveTick  (MoveTick),
    .FlipBtn   (FlipBtn),
    .Floor     (Floor),
    .Ceiling   (Ceiling),
    .OnCeil    (OnCeil),
    .Airborne  (Airborne),
    .Dead      (Dead),
    .Score     (Score),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  // Game view: which surface the player belongs to, whether a jump is in
  // flight and how many ticks of it remain, plus the button history seen
  // through the two-flop synchroniser (hist[0] = newest sample).
  typedef struct {
    bit       dead;
    bit       on_ceil;
    bit       airborne;
    int       air_left;
    int       score;
    bit       req;
    bit [2:0] hist;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.dead = 0; r.on_ceil = 0; r.airborne = 0; r.air_left = 0;
    r.score = 0; r.req = 0; r.hist = 3'b000;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input bit tick, input bit btn,
                                input bit [5:0] fl, input bit [5:0] ce);
    mdl_t n;
    bit edge_now;
    bit fs;
    bit cs;
    bit grounded;
    n        = cur;
    edge_now = cur.hist[1] & ~cur.hist[2];
    fs       = fl[PLAYER_COL];
    cs       = ce[PLAYER_COL];
    grounded = !cur.dead && !cur.airborne;
    n.hist   = {cur.hist[1], cur.hist[0], btn};
    if (tick) begin
      if (!cur.dead) begin
        if (grounded) begin
          if (cur.req || edge_now) begin
            n.airborne = 1;
            n.on_ceil  = !cur.on_ceil;
            n.air_left = FLIP_TICKS;
          end else if (!(cur.on_ceil ? cs : fs)) begin
            n.dead = 1;
          end
        end else begin
          n.air_left = cur.air_left - 1;
          if (n.air_left == 0) begin
            n.airborne = 0;
            if (!(cur.on_ceil ? cs : fs)) n.dead = 1;
          end
        end
        if (!n.dead && n.score < SCORE_MAX) n.score = n.score + 1;
      end
      n.req = 0;
    end else if (edge_now && grounded) begin
      n.req = 1;
    end
    return n;
  endfunction

  function automatic int exp_state(input mdl_t x);
    if (x.dead) return 4;
    if (x.airborne) return x.on_ceil ? 1 : 3;
    return x.on_ceil ? 2 : 0;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m <= mdl_reset();
    else      m <= step(m, MoveTick, FlipBtn, Floor, Ceiling);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_chk = n_chk + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Every cycle the registered outputs must match the game model.
  always @(negedge Clk) begin
    chk("model_oncеil", int'(OnCeil), int'(m.on_ceil));
    chk("model_airborne", int'(Airborne), int'(m.airborne));
    chk("model_dead", int'(Dead), int'(m.dead));
    chk("model_score", int'(Score), m.score);
    chk("model_state", int'(state_dbg), exp_state(m));
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  // One MoveTick pulse followed by quiet cycles.
  task automatic tick();
    MoveTick = 1'b1;
    @(posedge Clk);
    #2;
    MoveTick = 1'b0;
    idle(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    idle(2);
    Rst = 1'b1;
    idle(1);
  endtask

  task automatic chk_out(input string nm, input int oc, input int ab, input int dd, input int sc);
    chk({nm, "_oncеil"}, int'(OnCeil), oc);
    chk({nm, "_airborne"}, int'(Airborne), ab);
    chk({nm, "_dead"}, int'(Dead), dd);
    chk({nm, "_score"}, int'(Score), sc);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    n_chk = 0;
    n_pass = 0;
    Rst = 1'b0;
    MoveTick = 1'b0;
    FlipBtn = 1'b0;
    Floor = 6'b111111;
    Ceiling = 6'b000000;
    idle(2);
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_state", int'(state_dbg), 0);
    Rst = 1'b1;
    idle(1);

    // 1: solid floor, no button
    ticks(10);
    chk_out("t1", 0, 0, 0, 10);

    // 2: flip to a solid ceiling
    Ceiling = 6'b111111;
    FlipBtn = 1'b1;
    idle(3);
    tick();
    chk_out("t2_launch", 1, 1, 0, 11);
    FlipBtn = 1'b0;
    tick();
    chk_out("t2_air", 1, 1, 0, 12);
    tick();
    chk_out("t2_land", 1, 0, 0, 13);
    tick();
    chk_out("t2_ceil", 1, 0, 0, 14);
    chk("t2_state", int'(state_dbg), 2);

    // 3: gap under the player kills, score frozen afterwards
    do_reset();
    Ceiling = 6'b000000;
    Floor = 6'b111111;
    ticks(3);
    Floor = 6'b111101;
    tick();
    chk_out("t3_die", 0, 0, 1, 3);
    chk("t3_state", int'(state_dbg), 4);
    Floor = 6'b111111;
    ticks(20);
    chk_out("t3_frozen", 0, 0, 1, 3);

    // 4: edge in the MoveTick cycle rescues from the gap; empty ceiling kills
    do_reset();
    Floor = 6'b111101;
    Ceiling = 6'b000000;
    FlipBtn = 1'b1;
    idle(2);
    tick();
    chk_out("t4_launch", 1, 1, 0, 1);
    FlipBtn = 1'b0;
    tick();
    chk_out("t4_air", 1, 1, 0, 2);
    tick();
    chk_out("t4_land", 1, 0, 1, 2);

    // 5: second press while airborne is dropped
    do_reset();
    Floor = 6'b111111;
    Ceiling = 6'b111111;
    FlipBtn = 1'b1;
    idle(3);
    tick();
    FlipBtn = 1'b0;
    idle(1);
    FlipBtn = 1'b1;
    idle(3);
    ticks(2);
    chk_out("t5_land", 1, 0, 0, 3);
    ticks(3);
    chk_out("t5_nofollow", 1, 0, 0, 6);
    FlipBtn = 1'b0;
    idle(2);

    // 6: score saturation, then async reset mid-flip
    do_reset();
    Floor = 6'b111111;
    Ceiling = 6'b000000;
    MoveTick = 1'b1;
    repeat (10002) @(posedge Clk);
    #2;
    MoveTick = 1'b0;
    idle(1);
    chk("t6_sat", int'(Score), 9999);
    Ceiling = 6'b111111;
    FlipBtn = 1'b1;
    idle(3);
    tick();
    chk_out("t6_air", 1, 1, 0, 9999);
    FlipBtn = 1'b0;
    #1;
    Rst = 1'b0;
    #1;
    chk_out("t6_async", 0, 0, 0, 0);
    chk("t6_async_state", int'(state_dbg), 0);
    idle(2);
    Rst = 1'b1;
    idle(4);

    // pending request wiped by reset
    FlipBtn = 1'b1;
    idle(4);
    FlipBtn = 1'b0;
    Rst = 1'b0;
    idle(1);
    Rst = 1'b1;
    idle(3);
    tick();
    chk_out("t6_req_lost", 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
